// File: rtl/mult_add_fx_pkg.sv
// Shared constants and helpers for the fixed-point multiply-add family.
// Widths are derived here so every block sizes its sum/accumulator the same way.
// All helpers are constant-foldable and usable in localparam expressions.
package mult_add_fx_pkg;

   // Widest intermediate handled by the helpers below.
   localparam int MAX_W = 64;

   // Internal sum / accumulator width: data width plus integer guard bits.
   function automatic int acc_width(input int dw, input int guard);
      return dw + guard;
   endfunction

   // Half-LSB bias added to the 2*DW product before the DW-1 fraction bits are dropped.
   function automatic logic signed [MAX_W-1:0] round_bias(input int dw, input int round_en);
      if (round_en != 0) begin
         return 64'sd1 <<< (dw - 2);
      end
      return '0;
   endfunction

   // Clamp a signed value to the range representable in 'width' signed bits.
   function automatic logic signed [MAX_W-1:0] sat_trunc(input logic signed [MAX_W-1:0] value,
                                                         input int width);
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) begin
         return hi;
      end
      if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/mult_add_fx_sat.sv
// Narrows a signed IW-bit value to OW bits by clamping (SAT=1) or wrapping (SAT=0).
// Purely combinational, zero latency.
// ovf flags any input outside the OW-bit signed range, regardless of SAT.
module fx_sat #(
   parameter int IW  = 10,
   parameter int OW  = 8,
   parameter int SAT = 1
) (
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout,
   output logic                 ovf
);

   // In range exactly when all bits from the OW-1 sign position upward agree.
   always_comb begin
      ovf  = !((&din[IW-1:OW-1]) || !(|din[IW-1:OW-1]));
      dout = din[OW-1:0];
      if ((SAT != 0) && ovf) begin
         dout = din[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mult_add_fx.sv
// Pipelined signed Q1.(DW-1) multiply-add / multiply-accumulate with rounding and saturation.
// Latency 3 cycles (S1 product, S2 sum/accumulate, S3 output conversion), 1 sample/cycle.
// No backpressure: every valid sample is accepted and emitted; gaps pass through unchanged.
module mult_add_fx
   import mult_add_fx_pkg::*;
#(
   parameter int DW    = 8,
   parameter int GUARD = 2,
   parameter int ROUND = 0,
   parameter int SAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 val_in,
   input  logic signed [DW-1:0] a,
   input  logic signed [DW-1:0] b,
   input  logic signed [DW-1:0] c,
   input  logic                 acc_mode,
   input  logic                 acc_clr,
   input  logic                 ovf_clr,
   output logic signed [DW-1:0] s,
   output logic                 rdy_out,
   output logic                 ovf_out,
   output logic                 ovf_sticky
);

   localparam int ACC_W = acc_width(DW, GUARD);
   localparam int PW    = 2 * DW;
   localparam int PRW   = DW + 1;
   localparam logic signed [PW-1:0] BIAS = PW'(round_bias(DW, ROUND));

   // ---------------- S1: full-precision product and sideband ----------------
   logic signed [PW-1:0] p_d,  p_q;
   logic signed [DW-1:0] c1_d, c1_q;
   logic                 mode1_d, mode1_q;
   logic                 clr1_d,  clr1_q;
   logic                 vld1_d,  vld1_q;

   // Capture the product and the controls that travel with it.
   always_comb begin
      p_d     = a * b;
      c1_d    = c;
      mode1_d = acc_mode;
      clr1_d  = acc_clr;
      vld1_d  = val_in;
   end

   // S1 register bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q     <= '0;
         c1_q    <= '0;
         mode1_q <= 1'b0;
         clr1_q  <= 1'b0;
         vld1_q  <= 1'b0;
      end else begin
         p_q     <= p_d;
         c1_q    <= c1_d;
         mode1_q <= mode1_d;
         clr1_q  <= clr1_d;
         vld1_q  <= vld1_d;
      end
   end

   // ---------------- S2: product scaling, add or accumulate ----------------
   logic signed [PRW-1:0]   pr;
   logic signed [ACC_W-1:0] pr_ext;
   logic signed [ACC_W-1:0] c_ext;
   logic signed [ACC_W:0]   acc_sum;
   logic signed [MAX_W-1:0] acc_wide;
   logic signed [MAX_W-1:0] acc_clamp;
   logic                    acc_sat;
   logic                    acc_sat_evt;
   logic signed [ACC_W-1:0] acc_d,  acc_q;
   logic signed [ACC_W-1:0] sum_d,  sum_q;
   logic                    vld2_d, vld2_q;

   // Scale the product back to Q2.(DW-1), then form the sum for the selected mode.
   always_comb begin
      // The rounding add has headroom: |p| <= 2^(2DW-2), bias is only 2^(DW-2).
      pr       = PRW'((p_q + BIAS) >>> (DW - 1));
      pr_ext   = {{(ACC_W - PRW){pr[PRW-1]}}, pr};
      c_ext    = {{GUARD{c1_q[DW-1]}}, c1_q};
      // One extra bit so the raw accumulate cannot wrap before it is clamped.
      acc_sum  = {acc_q[ACC_W-1], acc_q} + {pr_ext[ACC_W-1], pr_ext};
      acc_wide = {{(MAX_W - ACC_W - 1){acc_sum[ACC_W]}}, acc_sum};
      acc_clamp = sat_trunc(acc_wide, ACC_W);
      acc_sat   = (acc_clamp != acc_wide);

      acc_d       = acc_q;
      sum_d       = sum_q;
      vld2_d      = vld1_q;
      acc_sat_evt = 1'b0;

      if (vld1_q) begin
         if (!mode1_q) begin
            // Add mode: guard bits absorb c + pr, the accumulator is left alone.
            sum_d = c_ext + pr_ext;
         end else if (clr1_q) begin
            // Fresh accumulation seeded with this sample's product.
            acc_d = pr_ext;
            sum_d = pr_ext;
         end else begin
            acc_d       = acc_clamp[ACC_W-1:0];
            sum_d       = acc_clamp[ACC_W-1:0];
            acc_sat_evt = acc_sat;
         end
      end else if (clr1_q) begin
         // A clear with no sample still restarts the accumulator from zero.
         acc_d = '0;
      end
   end

   // S2 register bank including the accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         sum_q  <= '0;
         vld2_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         sum_q  <= sum_d;
         vld2_q <= vld2_d;
      end
   end

   // ---------------- S3: narrow to DW bits, flag overflow ----------------
   logic signed [DW-1:0] sat_dat;
   logic                 sat_ovf;
   logic signed [DW-1:0] s_d,      s_q;
   logic                 ovf_d,    ovf_q;
   logic                 rdy_d,    rdy_q;
   logic                 sticky_d, sticky_q;

   fx_sat #(
      .IW  (ACC_W),
      .OW  (DW),
      .SAT (SAT)
   ) u_fx_sat (
      .din  (sum_q),
      .dout (sat_dat),
      .ovf  (sat_ovf)
   );

   // Outputs hold between valid samples; sticky set beats a same-cycle clear.
   always_comb begin
      s_d      = s_q;
      ovf_d    = ovf_q;
      rdy_d    = vld2_q;
      sticky_d = sticky_q;
      if (vld2_q) begin
         s_d   = sat_dat;
         ovf_d = sat_ovf;
      end
      if (ovf_clr) begin
         sticky_d = 1'b0;
      end
      if ((vld2_q && sat_ovf) || acc_sat_evt) begin
         sticky_d = 1'b1;
      end
   end

   // S3 output register bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q      <= '0;
         ovf_q    <= 1'b0;
         rdy_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         s_q      <= s_d;
         ovf_q    <= ovf_d;
         rdy_q    <= rdy_d;
         sticky_q <= sticky_d;
      end
   end

   assign s          = s_q;
   assign ovf_out    = ovf_q;
   assign rdy_out    = rdy_q;
   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_mult_add_fx.sv
// Drives three configurations of mult_add_fx (sat, wrap, round) with the same stimulus
// and compares every output cycle against an arithmetic reference model.
module tb_mult_add_fx;

   logic       clk = 1'b0;
   logic       rst;
   logic       val_in, acc_mode, acc_clr, ovf_clr;
   logic [7:0] a, b, c;

   logic [7:0] s_o   [3];
   logic       rdy_o [3];
   logic       ovf_o [3];
   logic       stk_o [3];

   int checks = 0;
   int errors = 0;

   // Instance configurations: 0 = ROUND0/SAT1, 1 = ROUND0/SAT0, 2 = ROUND1/SAT1.
   int RND  [3] = '{0, 0, 1};
   int SATC [3] = '{1, 0, 1};

   always #5 clk = ~clk;

   mult_add_fx #(.DW(8), .GUARD(2), .ROUND(0), .SAT(1)) dut_sat (
      .clk(clk), .rst(rst), .val_in(val_in), .a(a), .b(b), .c(c),
      .acc_mode(acc_mode), .acc_clr(acc_clr), .ovf_clr(ovf_clr),
      .s(s_o[0]), .rdy_out(rdy_o[0]), .ovf_out(ovf_o[0]), .ovf_sticky(stk_o[0]));

   mult_add_fx #(.DW(8), .GUARD(2), .ROUND(0), .SAT(0)) dut_wrap (
      .clk(clk), .rst(rst), .val_in(val_in), .a(a), .b(b), .c(c),
      .acc_mode(acc_mode), .acc_clr(acc_clr), .ovf_clr(ovf_clr),
      .s(s_o[1]), .rdy_out(rdy_o[1]), .ovf_out(ovf_o[1]), .ovf_sticky(stk_o[1]));

   mult_add_fx #(.DW(8), .GUARD(2), .ROUND(1), .SAT(1)) dut_rnd (
      .clk(clk), .rst(rst), .val_in(val_in), .a(a), .b(b), .c(c),
      .acc_mode(acc_mode), .acc_clr(acc_clr), .ovf_clr(ovf_clr),
      .s(s_o[2]), .rdy_out(rdy_o[2]), .ovf_out(ovf_o[2]), .ovf_sticky(stk_o[2]));

   // Reference model state, one copy per instance.
   int         m_acc [3];
   bit         m_stk [3];
   logic [7:0] m_s   [3];
   bit         m_ovf [3];

   typedef struct packed {
      logic            vld;
      logic [2:0][7:0] s;
      logic [2:0]      ovf;
   } exp_t;

   exp_t exp_q [$];

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, expv);
      end
   endtask

   // Wipe the model and account for the two cycles of emptied pipeline ahead of the output.
   task automatic model_reset();
      exp_t e;
      e = '0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = 0;
         m_stk[i] = 1'b0;
         m_s[i]   = 8'h00;
         m_ovf[i] = 1'b0;
      end
      exp_q.push_back(e);
      exp_q.push_back(e);
   endtask

   // Arithmetic reference: Q1.7 operands as plain integers, product scaled by 1/128 with floor.
   task automatic model(input bit v, input logic [7:0] ia, ib, ic, input bit md, cl);
      exp_t e;
      int   sa, sb, sc, p, pr, sum;
      sa = $signed(ia);
      sb = $signed(ib);
      sc = $signed(ic);
      e = '0;
      e.vld = v;
      for (int i = 0; i < 3; i++) begin
         if (v) begin
            p  = sa * sb;
            pr = (p + (RND[i] != 0 ? 64 : 0)) >>> 7;
            if (!md) begin
               sum = sc + pr;
            end else begin
               if (cl) begin
                  m_acc[i] = pr;
               end else begin
                  m_acc[i] = m_acc[i] + pr;
                  if (m_acc[i] > 511) begin
                     m_acc[i] = 511;
                     m_stk[i] = 1'b1;
                  end else if (m_acc[i] < -512) begin
                     m_acc[i] = -512;
                     m_stk[i] = 1'b1;
                  end
               end
               sum = m_acc[i];
            end
            if (sum > 127 || sum < -128) begin
               m_ovf[i] = 1'b1;
               m_stk[i] = 1'b1;
               if (SATC[i] != 0) m_s[i] = (sum > 127) ? 8'h7F : 8'h80;
               else              m_s[i] = sum[7:0];
            end else begin
               m_ovf[i] = 1'b0;
               m_s[i]   = sum[7:0];
            end
         end else if (cl) begin
            m_acc[i] = 0;
         end
         e.s[i]   = m_s[i];
         e.ovf[i] = m_ovf[i];
      end
      exp_q.push_back(e);
   endtask

   // One clock of stimulus; checks the output cycle due three samples ago.
   task automatic step(input bit v, input logic [7:0] ia, ib, ic, input bit md, cl, oc);
      exp_t e;
      val_in = v; a = ia; b = ib; c = ic; acc_mode = md; acc_clr = cl; ovf_clr = oc;
      model(v, ia, ib, ic, md, cl);
      if (oc) begin
         for (int i = 0; i < 3; i++) m_stk[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (exp_q.size() >= 3) begin
         e = exp_q.pop_front();
         for (int i = 0; i < 3; i++) begin
            chk("rdy_out", i, 32'(rdy_o[i]), 32'(e.vld));
            chk("s", i, 32'(s_o[i]), 32'(e.s[i]));
            chk("ovf_out", i, 32'(ovf_o[i]), 32'(e.ovf[i]));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_sticky();
      for (int i = 0; i < 3; i++) chk("ovf_sticky", i, 32'(stk_o[i]), 32'(m_stk[i]));
   endtask

   // Asynchronous reset mid-cycle, checked before any clock edge can act.
   task automatic do_reset();
      #1;
      rst = 1'b1;
      val_in = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0; ovf_clr = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_s", i, 32'(s_o[i]), 32'h0);
         chk("rst_rdy", i, 32'(rdy_o[i]), 32'h0);
         chk("rst_ovf", i, 32'(ovf_o[i]), 32'h0);
         chk("rst_sticky", i, 32'(stk_o[i]), 32'h0);
      end
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] ra, rb, rc;
      bit         rv, rm, rcl;
      bit         gap [5];

      rst = 1'b0;
      val_in = 1'b0; a = 8'h00; b = 8'h00; c = 8'h00;
      acc_mode = 1'b0; acc_clr = 1'b0; ovf_clr = 1'b0;
      @(posedge clk);
      do_reset();

      // Basic add: 0.5*0.5 + 0.125 = 0.375 -> 0x30.
      step(1'b1, 8'h40, 8'h40, 8'h10, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Positive and negative overflow, then sticky clear.
      step(1'b1, 8'h80, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h80, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk_sticky();
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      chk_sticky();
      idle(2);

      // Rounding of a half-LSB product.
      step(1'b1, 8'h01, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Accumulate four quarters, then a mode-0 sample, then continue accumulating.
      step(1'b1, 8'h40, 8'h40, 8'h55, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h40, 8'h40, 8'h55, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h40, 8'h40, 8'h55, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h40, 8'h40, 8'h55, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h01, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h40, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_sticky();

      // Clear without a sample, then accumulate from zero.
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h30, 8'hD0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(3);

      // Valid gaps 1,0,1,1,0 with random add-mode data.
      gap = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 8'($urandom_range(0, 255));
         step(gap[k], ra, rb, rc, 1'b0, 1'b0, 1'b0);
      end
      idle(3);

      // Random mixed traffic.
      for (int k = 0; k < 300; k++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rc  = 8'($urandom_range(0, 255));
         rv  = ($urandom_range(0, 3) != 0);
         rm  = ($urandom_range(0, 2) != 0);
         rcl = ($urandom_range(0, 9) == 0);
         step(rv, ra, rb, rc, rm, rcl, 1'b0);
      end
      idle(3);
      chk_sticky();
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      chk_sticky();
      idle(2);

      // Reset with samples in flight and a non-zero accumulator.
      step(1'b1, 8'h40, 8'h40, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h7F, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
      do_reset();
      idle(4);
      step(1'b1, 8'h40, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_sticky();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
